// File: rtl/keypad_reader.sv
`default_nettype none
// ============================================================================
// Module   : keypad_reader
// Brief    : 4x4 matrix keypad scanner with debounce and two-digit product
//            entry. Define KEYPAD_TIMEOUT_EN to abandon stale partial entries.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_reader #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned TIMEOUT_FRAMES = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] produto,
    output logic       produto_valid,
    output logic [1:0] entry_state
);

    localparam int unsigned             c_div_w      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned             c_dbc_w      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [c_div_w-1:0]      c_div_last   = c_div_w'(SCAN_DIV - 1);
    localparam logic [c_dbc_w-1:0]      c_dbc_target = c_dbc_w'(DEBOUNCE_SCANS);
    localparam logic [3:0]              c_code_clear = 4'hE;
    localparam logic [3:0]              c_code_conf  = 4'hF;
    localparam logic [3:0]              c_code_bad   = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_D1   = 2'b01,
        S_D2   = 2'b10
    } state_t;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0:    k = 4'h1;
            4'h1:    k = 4'h2;
            4'h2:    k = 4'h3;
            4'h3:    k = 4'hA;
            4'h4:    k = 4'h4;
            4'h5:    k = 4'h5;
            4'h6:    k = 4'h6;
            4'h7:    k = 4'hB;
            4'h8:    k = 4'h7;
            4'h9:    k = 4'h8;
            4'hA:    k = 4'h9;
            4'hB:    k = 4'hC;
            4'hC:    k = 4'hE;
            4'hD:    k = 4'h0;
            4'hE:    k = 4'hF;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    logic [c_div_w-1:0] r_div;
    logic [1:0]         r_col_idx;
    logic [3:0]         r_row_s1;
    logic [3:0]         r_row_s2;
    logic [1:0]         r_acc_cnt;
    logic [3:0]         r_acc_key;
    logic [4:0]         r_hist;
    logic [c_dbc_w-1:0] r_match;
    logic [4:0]         r_stable;
    logic               r_key_valid;
    logic [3:0]         r_key_code;
    state_t             r_state;
    logic [3:0]         r_d1;
    logic [3:0]         r_d2;
    logic [3:0]         r_produto;
    logic               r_produto_valid;

    logic               w_sample;
    logic               w_frame_end;
    logic [2:0]         w_slot_cnt;
    logic [1:0]         w_slot_row;
    logic [2:0]         w_acc_sum;
    logic [1:0]         w_tot;
    logic [3:0]         w_key;
    logic [4:0]         w_res;
    logic [c_dbc_w-1:0] w_match_next;
    logic               w_tmo_fire;
    logic               w_is_digit;
    logic [3:0]         w_conf_code;
    state_t             w_state_next;
    logic [3:0]         w_d1_next;
    logic [3:0]         w_d2_next;
    logic [3:0]         w_produto_next;
    logic               w_pv_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
            r_row_s1  <= 4'hF;
            r_row_s2  <= 4'hF;
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
            if (r_div == c_div_last) begin
                r_div     <= '0;
                r_col_idx <= r_col_idx + 2'd1;
            end else begin
                r_div <= r_div + c_div_w'(1);
            end
        end
    end

    assign col         = ~(4'b0001 << r_col_idx);
    assign w_sample    = (r_div == c_div_last);
    assign w_frame_end = w_sample && (r_col_idx == 2'd3);

    // Per-slot key count; the frame total saturates at 2 so any multi-key frame is rejected.
    always_comb begin
        w_slot_cnt = 3'd0;
        w_slot_row = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!r_row_s2[i]) begin
                w_slot_cnt = w_slot_cnt + 3'd1;
                w_slot_row = 2'(i);
            end
        end
    end

    assign w_acc_sum = {1'b0, r_acc_cnt} + w_slot_cnt;
    assign w_tot     = (w_acc_sum >= 3'd2) ? 2'd2 : w_acc_sum[1:0];
    assign w_key     = (w_slot_cnt == 3'd1) ? key_map(w_slot_row, r_col_idx) : r_acc_key;
    assign w_res     = (w_tot == 2'd1) ? {1'b1, w_key} : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_cnt <= 2'd0;
            r_acc_key <= 4'd0;
        end else if (w_sample) begin
            if (r_col_idx == 2'd3) begin
                r_acc_cnt <= 2'd0;
                r_acc_key <= 4'd0;
            end else begin
                r_acc_cnt <= w_tot;
                r_acc_key <= w_key;
            end
        end
    end

    always_comb begin
        if (w_res == r_hist) begin
            w_match_next = (r_match == c_dbc_target) ? r_match : r_match + c_dbc_w'(1);
        end else begin
            w_match_next = c_dbc_w'(1);
        end
    end

    // Only a stable none->key transition is an event; key->key just re-arms nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist      <= 5'd0;
            r_match     <= '0;
            r_stable    <= 5'd0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_frame_end) begin
                r_hist  <= w_res;
                r_match <= w_match_next;
                if ((w_match_next == c_dbc_target) && (w_res != r_stable)) begin
                    r_stable <= w_res;
                    if (!r_stable[4] && w_res[4]) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_res[3:0];
                    end
                end
            end
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    localparam int unsigned        c_tmo_w     = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_limit = c_tmo_w'(TIMEOUT_FRAMES);

    logic [c_tmo_w-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if (r_key_valid) begin
            r_tmo_cnt <= '0;
        end else if (w_frame_end && (r_tmo_cnt != c_tmo_limit)) begin
            r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
        end
    end

    assign w_tmo_fire = (r_tmo_cnt == c_tmo_limit);
`else
    assign w_tmo_fire = 1'b0;
`endif

    assign w_is_digit = (r_key_code <= 4'd9);

    always_comb begin
        case ({r_d1, r_d2})
            8'h00, 8'h10, 8'h11, 8'h20, 8'h21,
            8'h22, 8'h23, 8'h30, 8'h31: w_conf_code = {r_d1[1:0], r_d2[1:0]};
            default:                    w_conf_code = c_code_bad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_d1            <= 4'd0;
            r_d2            <= 4'd0;
            r_produto       <= c_code_bad;
            r_produto_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_d1            <= w_d1_next;
            r_d2            <= w_d2_next;
            r_produto       <= w_produto_next;
            r_produto_valid <= w_pv_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_d1_next      = r_d1;
        w_d2_next      = r_d2;
        w_produto_next = r_produto;
        w_pv_next      = 1'b0;
        if (r_key_valid) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_digit) begin
                        w_d1_next    = r_key_code;
                        w_state_next = S_D1;
                    end
                end
                S_D1: begin
                    if (w_is_digit) begin
                        w_d2_next    = r_key_code;
                        w_state_next = S_D2;
                    end else if (r_key_code == c_code_clear) begin
                        w_state_next = S_IDLE;
                    end else if (r_key_code == c_code_conf) begin
                        w_produto_next = c_code_bad;
                        w_pv_next      = 1'b1;
                        w_state_next   = S_IDLE;
                    end
                end
                S_D2: begin
                    if (r_key_code == c_code_clear) begin
                        w_state_next = S_IDLE;
                    end else if (r_key_code == c_code_conf) begin
                        w_produto_next = w_conf_code;
                        w_pv_next      = 1'b1;
                        w_state_next   = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end else if (w_tmo_fire && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end
    end

    assign key_code      = r_key_code;
    assign key_valid     = r_key_valid;
    assign produto       = r_produto;
    assign produto_valid = r_produto_valid;
    assign entry_state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_keypad_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_reader
// Brief    : Scoreboard bench for keypad_reader with a modelled 4x4 key matrix.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_reader;

    localparam int c_scan_div = 4;
    localparam int c_dbc      = 3;
    localparam int c_tmo      = 10;
    localparam int c_frame    = 4 * c_scan_div;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] produto;
    logic       produto_valid;
    logic [1:0] entry_state;

    logic [15:0] pressed = 16'd0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          kv_count = 0;
    int          last_kv_cyc = 0;
    logic [3:0]  exp_key[$];
    logic [3:0]  exp_prod[$];

    keypad_reader #(
        .SCAN_DIV       (c_scan_div),
        .DEBOUNCE_SCANS (c_dbc),
        .TIMEOUT_FRAMES (c_tmo)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .row           (row),
        .col           (col),
        .key_code      (key_code),
        .key_valid     (key_valid),
        .produto       (produto),
        .produto_valid (produto_valid),
        .entry_state   (entry_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key r*4+c pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row[r] = ~|(pressed[r*4 +: 4] & ~col);
        end
    end

    function automatic int pos_of(input logic [3:0] code);
        case (code)
            4'h1: return 0;   4'h2: return 1;   4'h3: return 2;   4'hA: return 3;
            4'h4: return 4;   4'h5: return 5;   4'h6: return 6;   4'hB: return 7;
            4'h7: return 8;   4'h8: return 9;   4'h9: return 10;  4'hC: return 11;
            4'hE: return 12;  4'h0: return 13;  4'hF: return 14;  default: return 15;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sync_frame();
        int k;
        k = 0;
        while (col !== 4'b0111 && k < 4 * c_frame) begin @(negedge clk); k++; end
        while (col !== 4'b1110 && k < 4 * c_frame) begin @(negedge clk); k++; end
        if (k >= 4 * c_frame) begin
            n_vec++;
            n_err++;
            $display("FAIL sync_frame: col stuck at %b expected rotation", col);
        end
    endtask

    task automatic tap(input logic [3:0] code);
        exp_key.push_back(code);
        pressed[pos_of(code)] = 1'b1;
        wait_cycles(4 * c_frame);
        pressed = 16'd0;
        wait_cycles(3 * c_frame);
    endtask

    task automatic entry(input logic [3:0] a, input logic [3:0] b, input logic [3:0] prod);
        tap(a);
        tap(b);
        exp_prod.push_back(prod);
        tap(4'hF);
        check("produto_held", int'(produto), int'(prod));
        check("state_after_confirm", int'(entry_state), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (key_valid) begin
                kv_count++;
                last_kv_cyc = cyc;
                if (exp_key.size() == 0) begin
                    check("unexpected_key_valid", int'(key_code), -1);
                end else begin
                    check("key_code", int'(key_code), int'(exp_key.pop_front()));
                end
            end
            if (produto_valid) begin
                if (exp_prod.size() == 0) begin
                    check("unexpected_produto_valid", int'(produto), -1);
                end else begin
                    check("produto", int'(produto), int'(exp_prod.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t0;
        int         kv0;
        logic [3:0] e;

        wait_cycles(3);
        check("rst_col", int'(col), 'hE);
        check("rst_key_code", int'(key_code), 0);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_produto", int'(produto), 'hF);
        check("rst_produto_valid", int'(produto_valid), 0);
        check("rst_entry_state", int'(entry_state), 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            e = ~(4'b0001 << ((k / 4) % 4));
            check("col_rotation", int'(col), int'(e));
        end

        sync_frame();
        tap(4'h2);
        check("state_one_digit", int'(entry_state), 1);
        tap(4'h3);
        check("state_two_digits", int'(entry_state), 2);
        exp_prod.push_back(4'b1011);
        tap(4'hF);
        check("produto_23", int'(produto), 'hB);
        check("state_after_confirm", int'(entry_state), 0);

        tap(4'h2);
        exp_prod.push_back(4'b1111);
        tap(4'hF);
        check("produto_one_digit", int'(produto), 'hF);

        entry(4'h3, 4'h1, 4'b1101);
        entry(4'h5, 4'h0, 4'b1111);
        entry(4'h0, 4'h0, 4'b0000);
        entry(4'h1, 4'h2, 4'b1111);

        tap(4'hA);
        check("letter_ignored_idle", int'(entry_state), 0);
        tap(4'h2);
        tap(4'h0);
        tap(4'h7);
        tap(4'hB);
        check("extra_ignored_d2", int'(entry_state), 2);
        exp_prod.push_back(4'b1000);
        tap(4'hF);
        check("produto_20", int'(produto), 'h8);

        tap(4'h3);
        check("clear_pre", int'(entry_state), 1);
        tap(4'hE);
        check("clear_state", int'(entry_state), 0);
        check("clear_produto_kept", int'(produto), 'h8);

        // Bounce: one frame pressed, one released, then held.
        sync_frame();
        kv0 = kv_count;
        pressed[pos_of(4'h1)] = 1'b1;
        wait_cycles(c_frame);
        pressed = 16'd0;
        wait_cycles(c_frame);
        exp_key.push_back(4'h1);
        pressed[pos_of(4'h1)] = 1'b1;
        t0 = cyc;
        wait_cycles(4 * c_frame);
        check("bounce_pulses", kv_count - kv0, 1);
        check("bounce_latency", last_kv_cyc - t0, c_dbc * c_frame);
        pressed = 16'd0;
        wait_cycles(3 * c_frame);
        tap(4'hE);

        // Ghost: 1 and 2 together, then 2 released.
        kv0 = kv_count;
        pressed[pos_of(4'h1)] = 1'b1;
        pressed[pos_of(4'h2)] = 1'b1;
        wait_cycles(5 * c_frame);
        check("ghost_no_event", kv_count - kv0, 0);
        pressed[pos_of(4'h2)] = 1'b0;
        exp_key.push_back(4'h1);
        t0 = cyc;
        wait_cycles(4 * c_frame);
        check("ghost_single_pulse", kv_count - kv0, 1);
        check("ghost_latency", last_kv_cyc - t0, c_dbc * c_frame);
        pressed = 16'd0;
        wait_cycles(3 * c_frame);
        tap(4'hE);

        // Reset in the middle of an entry and a debounce.
        tap(4'h3);
        pressed[pos_of(4'h5)] = 1'b1;
        wait_cycles(2 * c_frame);
        rst_n = 1'b0;
        wait_cycles(2);
        check("midrst_state", int'(entry_state), 0);
        check("midrst_produto", int'(produto), 'hF);
        check("midrst_col", int'(col), 'hE);
        pressed = 16'd0;
        rst_n = 1'b1;
        sync_frame();
        entry(4'h2, 4'h2, 4'b1010);

`ifdef KEYPAD_TIMEOUT_EN
        tap(4'h1);
        check("tmo_pre_state", int'(entry_state), 1);
        wait_cycles(c_tmo * c_frame);
        check("tmo_state", int'(entry_state), 0);
        check("tmo_produto_kept", int'(produto), 'hA);
        entry(4'h2, 4'h1, 4'b1001);
`endif

        wait_cycles(2 * c_frame);
        while (exp_key.size() != 0) begin
            check("missing_key_valid", -1, int'(exp_key.pop_front()));
        end
        while (exp_prod.size() != 0) begin
            check("missing_produto_valid", -1, int'(exp_prod.pop_front()));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
